keypad_entry_ctrl: RTL and testbench

Sequences a 10-key decimal keypad into a multi-digit BCD entry. Raw active-high key lines are priority-encoded to BCD, debounced, and accepted once per press/release. Accepted digits shift into a DIGITS-wide entry register, which an enter strobe commits. Sits between the keypad input pins and downstream consumers (display driver, code comparator, calculator core).

---
 rtl/keypad_entry_ctrl.sv | 166 ++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Decimal keypad front end: priority-encodes raw key lines, debounces press and
// release, and shifts accepted BCD digits into an entry register committed by enter.
module keypad_entry_ctrl #(
  parameter int DIGITS   = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            keys,
  input  logic                  enter,
  input  logic                  clear,
  output logic                  key_valid,
  output logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   digits,
  output logic [3:0]            digit_count,
  output logic                  entry_valid,
  output logic [4*DIGITS-1:0]   entry_value,
  output logic                  overflow
);

  localparam logic [7:0] DB_LEN   = 8'(DEBOUNCE);
  localparam logic [3:0] MAX_CNT  = 4'(DIGITS);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next, cnt_inc;
  logic [3:0]  cand_reg, cand_next;
  logic [3:0]  code;
  logic        key_any;
  logic        accept;

  logic                 key_valid_reg, entry_valid_reg, overflow_reg;
  logic [3:0]           key_code_reg, count_reg;
  logic [4*DIGITS-1:0]  digits_reg, entry_value_reg, digits_shifted;

  // Highest asserted key wins when several lines are high.
  always_comb begin
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) code = 4'(i);
    end
  end

  assign key_any = |keys;
  assign cnt_inc = cnt_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      cand_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
    end
  end

  // cand_next always carries the digit being accepted when accept is high.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_any) begin
          cand_next = code;
          if (DEBOUNCE == 1) begin
            state_next = HELD;
            accept     = 1'b1;
          end else begin
            state_next = PRESS_DB;
            cnt_next   = 8'd1;
          end
        end
      end
      PRESS_DB: begin
        if (!key_any) begin
          state_next = IDLE;
        end else if (code != cand_reg) begin
          cand_next = code;
          cnt_next  = 8'd1;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == DB_LEN) begin
            state_next = HELD;
            accept     = 1'b1;
          end
        end
      end
      HELD: begin
        if (!key_any) begin
          if (DEBOUNCE == 1) begin
            state_next = IDLE;
          end else begin
            state_next = RELEASE_DB;
            cnt_next   = 8'd1;
          end
        end
      end
      RELEASE_DB: begin
        if (key_any) begin
          state_next = HELD;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == DB_LEN) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // New digit enters nibble 0; older digits move up one nibble.
  genvar gi;
  assign digits_shifted[3:0] = cand_next;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_shift
      assign digits_shifted[4*gi +: 4] = digits_reg[4*(gi-1) +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_reg   <= 1'b0;
      key_code_reg    <= 4'd0;
      digits_reg      <= '0;
      count_reg       <= 4'd0;
      entry_valid_reg <= 1'b0;
      entry_value_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      key_valid_reg   <= accept;
      entry_valid_reg <= 1'b0;
      if (accept) key_code_reg <= cand_next;
      if (clear) begin
        digits_reg   <= '0;
        count_reg    <= 4'd0;
        overflow_reg <= 1'b0;
      end else if (enter && count_reg != 4'd0) begin
        entry_value_reg <= digits_reg;
        entry_valid_reg <= 1'b1;
        digits_reg      <= '0;
        count_reg       <= 4'd0;
        overflow_reg    <= 1'b0;
      end else if (accept) begin
        if (count_reg < MAX_CNT) begin
          digits_reg <= digits_shifted;
          count_reg  <= count_reg + 4'd1;
        end else begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  assign key_valid   = key_valid_reg;
  assign key_code    = key_code_reg;
  assign digits      = digits_reg;
  assign digit_count = count_reg;
  assign entry_valid = entry_valid_reg;
  assign entry_value = entry_value_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios then random key activity, all
// checked every cycle against a run-length / digit-queue reference model.
module tb_keypad_entry_ctrl;

  localparam int DIGITS   = 4;
  localparam int DEBOUNCE = 4;

  logic                clk = 1'b0;
  logic                rst, enter, clear;
  logic [9:0]          keys;
  logic                key_valid, entry_valid, overflow;
  logic [3:0]          key_code, digit_count;
  logic [4*DIGITS-1:0] digits, entry_value;

  int vectors = 0;
  int miscompares = 0;

  keypad_entry_ctrl #(.DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .keys(keys), .enter(enter), .clear(clear),
    .key_valid(key_valid), .key_code(key_code), .digits(digits),
    .digit_count(digit_count), .entry_valid(entry_valid),
    .entry_value(entry_value), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model state: a pressed flag plus run lengths of identical samples,
  // and the entry kept as a queue of digits (oldest first).
  bit          m_held;
  int          m_run, m_rel, m_cand;
  int          q[$];
  bit          m_kv, m_ev, m_ovf;
  logic [31:0] m_kc, m_entry;

  function automatic int enc(input logic [9:0] k);
    int c = 0;
    for (int i = 0; i < 10; i++) if (k[i]) c = i;
    return c;
  endfunction

  function automatic logic [31:0] q_value();
    logic [31:0] v = 32'd0;
    foreach (q[i]) v = (v << 4) | 32'(q[i]);
    return v;
  endfunction

  task automatic model_edge(input logic [9:0] k, input logic en, input logic cl, input logic r);
    int acc = -1;
    m_kv = 1'b0;
    m_ev = 1'b0;
    if (r) begin
      m_held = 0; m_run = 0; m_rel = 0; m_cand = 0;
      q.delete(); m_ovf = 0; m_kc = 0; m_entry = 0;
      return;
    end
    if (!m_held) begin
      if (k == 10'd0) m_run = 0;
      else if (m_run > 0 && enc(k) == m_cand) m_run++;
      else begin m_cand = enc(k); m_run = 1; end
      if (m_run == DEBOUNCE) begin acc = m_cand; m_held = 1; m_rel = 0; m_run = 0; end
    end else begin
      if (k != 10'd0) m_rel = 0; else m_rel++;
      if (m_rel == DEBOUNCE) begin m_held = 0; m_run = 0; end
    end
    if (acc >= 0) begin m_kv = 1'b1; m_kc = 32'(acc); end
    if (cl) begin
      q.delete(); m_ovf = 0;
    end else if (en && q.size() > 0) begin
      m_entry = q_value(); m_ev = 1'b1; q.delete(); m_ovf = 0;
    end else if (acc >= 0) begin
      if (q.size() < DIGITS) q.push_back(acc); else m_ovf = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("key_valid",   32'(key_valid),   32'(m_kv));
    chk("key_code",    32'(key_code),    m_kc);
    chk("digits",      32'(digits),      q_value());
    chk("digit_count", 32'(digit_count), 32'(q.size()));
    chk("entry_valid", 32'(entry_valid), 32'(m_ev));
    chk("entry_value", 32'(entry_value), m_entry);
    chk("overflow",    32'(overflow),    32'(m_ovf));
  endtask

  task automatic step(input logic [9:0] k, input logic en, input logic cl, input logic r);
    keys = k; enter = en; clear = cl; rst = r;
    @(posedge clk);
    model_edge(k, en, cl, r);
    #1;
    check_all();
    if (m_kv) $display("t=%0t key accepted code=%0d digits=%h count=%0d", $time, key_code, digits, digit_count);
    if (m_ev) $display("t=%0t entry committed value=%h", $time, entry_value);
  endtask

  task automatic press(input logic [9:0] k, input int hold, input int rel);
    for (int i = 0; i < hold; i++) step(k, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < rel; i++) step(10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [9:0] rk;
    int         len;
    keys = 10'd0; enter = 1'b0; clear = 1'b0; rst = 1'b1;

    // Reset then a single press of key 3
    step(10'd0, 1'b0, 1'b0, 1'b1);
    step(10'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_digits", 32'(digits), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(10'b0000001000, 1'b0, 1'b0, 1'b0);
      if (i == 4) begin
        chk("single_kv", 32'(key_valid), 32'd1);
        chk("single_code", 32'(key_code), 32'd3);
        chk("single_digits", 32'(digits), 32'h0003);
      end
    end
    press(10'd0, 0, 8);

    // Bounce on key 5, then a clean hold
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 10'b0000100000 : 10'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(10'b0000100000, 1'b0, 1'b0, 1'b0);
      if (i == DEBOUNCE) chk("bounce_code", 32'(key_code), 32'd5);
    end
    press(10'd0, 0, 6);

    // Two keys together, then drop the higher one while held
    press(10'b0010000100, 6, 0);
    press(10'b0000000100, 4, 6);
    press(10'b0000000100, 6, 6);
    chk("multikey_code", 32'(key_code), 32'd2);

    // Fill and overflow
    step(10'd0, 1'b0, 1'b1, 1'b0);
    for (int d = 1; d <= 5; d++) begin
      press(10'(1) << d, 5, 5);
      if (d == 4) chk("fill_digits", 32'(digits), 32'h1234);
    end
    chk("ovf_digits", 32'(digits), 32'h1234);
    chk("ovf_flag", 32'(overflow), 32'd1);

    // Commit, then a second enter that must be ignored
    step(10'd0, 1'b1, 1'b0, 1'b0);
    chk("commit_value", 32'(entry_value), 32'h1234);
    step(10'd0, 1'b0, 1'b0, 1'b0);
    step(10'd0, 1'b1, 1'b0, 1'b0);
    chk("second_enter", 32'(entry_valid), 32'd0);

    // clear + enter on the accepting edge of a digit
    press(10'b1000000000, 6, 6);
    chk("prio_pre", 32'(digits), 32'h0009);
    for (int i = 0; i < DEBOUNCE - 1; i++) step(10'b0000010000, 1'b0, 1'b0, 1'b0);
    step(10'b0000010000, 1'b1, 1'b1, 1'b0);
    chk("prio_kv", 32'(key_valid), 32'd1);
    chk("prio_digits", 32'(digits), 32'd0);
    chk("prio_entry", 32'(entry_value), 32'h1234);
    press(10'b0000010000, 2, 6);

    // Random key activity with occasional enter, clear and reset
    for (int s = 0; s < 400; s++) begin
      len = $urandom_range(1, 8);
      case ($urandom_range(0, 3))
        0:       rk = 10'd0;
        3:       rk = 10'($urandom);
        default: rk = 10'(1) << $urandom_range(0, 9);
      endcase
      for (int c = 0; c < len; c++)
        step(rk, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
